// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared definitions for the instruction/data memory bus arbiter:
//   - default address/data widths
//   - FSM state encoding (IDLE=0, I_ADDR=1, I_DATA=2, D_ADDR=3, D_DATA=4)
//   - small state-decode helpers
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    localparam int AW_DEFAULT = 32;
    localparam int DW_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_ADDR = 3'd1,
        ST_I_DATA = 3'd2,
        ST_D_ADDR = 3'd3,
        ST_D_DATA = 3'd4
    } arb_state_e;

    // True while the bus address phase is being presented.
    function automatic logic is_addr_phase(input arb_state_e st);
        return (st == ST_I_ADDR) || (st == ST_D_ADDR);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Serialises instruction-fetch and data accesses onto one SRAM-like bus with
// split address/data handshakes. Data always wins over instruction when both
// are waiting. Each request is latched at grant; the bus outputs are driven
// from the latched fields and the state register only (no input-to-bus path).
// Read data is captured into per-requester registers and a one-cycle done
// pulse is issued the cycle after the bus response. stall_o is asserted while
// either requester has an access outstanding.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   inst_req/inst_addr       fetch request (held until inst_done)
//   inst_rdata/inst_done     fetched word and completion pulse
//   data_req/data_wen/...    load/store request (held until data_done)
//   data_rdata/data_done     load word and completion pulse
//   flush                    pipeline exception flush
//   stall_o                  stall request to the hazard unit
//   bus_req/bus_wr/bus_wstrb/bus_addr/bus_wdata   address phase outputs
//   bus_addr_ok/bus_data_ok/bus_rdata             bus handshake inputs
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            inst_req,
    input  logic [AW-1:0]   inst_addr,
    output logic [DW-1:0]   inst_rdata,
    output logic            inst_done,

    input  logic            data_req,
    input  logic [DW/8-1:0] data_wen,
    input  logic [AW-1:0]   data_addr,
    input  logic [DW-1:0]   data_wdata,
    output logic [DW-1:0]   data_rdata,
    output logic            data_done,

    input  logic            flush,
    output logic            stall_o,

    output logic            bus_req,
    output logic            bus_wr,
    output logic [DW/8-1:0] bus_wstrb,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    input  logic            bus_addr_ok,
    input  logic            bus_data_ok,
    input  logic [DW-1:0]   bus_rdata
);

    localparam int SW = DW / 8;

    arb_state_e      state_r;
    arb_state_e      state_next_s;

    logic [AW-1:0]   addr_r;
    logic [SW-1:0]   wen_r;
    logic [DW-1:0]   wdata_r;
    logic [DW-1:0]   inst_rdata_r;
    logic [DW-1:0]   data_rdata_r;
    logic            inst_done_r;
    logic            data_done_r;
    // Set when a flush hits an access that can no longer be abandoned on the
    // bus; the response is then consumed silently.
    logic            kill_r;
    logic            kill_next_s;

    logic            inst_pend_s;
    logic            data_pend_s;
    logic            grant_inst_s;
    logic            grant_data_s;
    logic            inst_capture_s;
    logic            data_capture_s;

    // A request is still pending only if its done pulse is not showing this
    // cycle; this keeps a held request from being re-granted in its done
    // cycle and lets the other requester take the bus instead.
    always_comb begin
        inst_pend_s = inst_req & ~inst_done_r;
        data_pend_s = data_req & ~data_done_r;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, grant and completion decode.
    always_comb begin
        state_next_s   = state_r;
        kill_next_s    = kill_r;
        grant_inst_s   = 1'b0;
        grant_data_s   = 1'b0;
        inst_capture_s = 1'b0;
        data_capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                kill_next_s = 1'b0;
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else if (data_pend_s) begin
                    grant_data_s = 1'b1;
                    state_next_s = ST_D_ADDR;
                end else if (inst_pend_s) begin
                    grant_inst_s = 1'b1;
                    state_next_s = ST_I_ADDR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_I_ADDR: begin
                // Once the address is accepted the access must finish on the
                // bus, so a same-cycle flush only marks it as killed.
                if (bus_addr_ok) begin
                    state_next_s = ST_I_DATA;
                    kill_next_s  = flush;
                end else if (flush) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_I_ADDR;
                end
            end
            ST_I_DATA: begin
                if (bus_data_ok) begin
                    state_next_s   = ST_IDLE;
                    inst_capture_s = ~(kill_r | flush);
                    kill_next_s    = 1'b0;
                end else begin
                    state_next_s = ST_I_DATA;
                    kill_next_s  = kill_r | flush;
                end
            end
            ST_D_ADDR: begin
                if (bus_addr_ok) begin
                    state_next_s = ST_D_DATA;
                    kill_next_s  = flush;
                end else if (flush) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_D_ADDR;
                end
            end
            ST_D_DATA: begin
                if (bus_data_ok) begin
                    state_next_s   = ST_IDLE;
                    data_capture_s = ~(kill_r | flush);
                    kill_next_s    = 1'b0;
                end else begin
                    state_next_s = ST_D_DATA;
                    kill_next_s  = kill_r | flush;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                kill_next_s  = 1'b0;
            end
        endcase
    end

    // Request latches, response capture and done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r       <= {AW{1'b0}};
            wen_r        <= {SW{1'b0}};
            wdata_r      <= {DW{1'b0}};
            inst_rdata_r <= {DW{1'b0}};
            data_rdata_r <= {DW{1'b0}};
            inst_done_r  <= 1'b0;
            data_done_r  <= 1'b0;
            kill_r       <= 1'b0;
        end else begin
            kill_r      <= kill_next_s;
            inst_done_r <= inst_capture_s;
            data_done_r <= data_capture_s;
            if (grant_data_s) begin
                addr_r  <= data_addr;
                wen_r   <= data_wen;
                wdata_r <= data_wdata;
            end else if (grant_inst_s) begin
                addr_r  <= inst_addr;
            end else begin
                addr_r  <= addr_r;
            end
            if (inst_capture_s) begin
                inst_rdata_r <= bus_rdata;
            end else begin
                inst_rdata_r <= inst_rdata_r;
            end
            if (data_capture_s) begin
                data_rdata_r <= bus_rdata;
            end else begin
                data_rdata_r <= data_rdata_r;
            end
        end
    end

    // Bus outputs decoded from the state register and latched fields only.
    always_comb begin
        bus_req   = is_addr_phase(state_r);
        bus_addr  = addr_r;
        bus_wdata = wdata_r;
        if (state_r == ST_D_ADDR) begin
            bus_wr    = |wen_r;
            bus_wstrb = wen_r;
        end else begin
            bus_wr    = 1'b0;
            bus_wstrb = {SW{1'b0}};
        end
    end

    // Requester-side outputs.
    always_comb begin
        inst_rdata = inst_rdata_r;
        data_rdata = data_rdata_r;
        inst_done  = inst_done_r;
        data_done  = data_done_r;
        stall_o    = (inst_req & ~inst_done_r) | (data_req & ~data_done_r);
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed scenarios followed by a randomized phase. Expected values come from
// a transaction-level reference model (one in-flight access record with
// "address accepted" and "killed" flags) plus constants in directed steps.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inst_req = 1'b0;
    logic [AW-1:0] inst_addr = '0;
    logic [DW-1:0] inst_rdata;
    logic          inst_done;
    logic          data_req = 1'b0;
    logic [SW-1:0] data_wen = '0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic [DW-1:0] data_rdata;
    logic          data_done;
    logic          flush = 1'b0;
    logic          stall_o;
    logic          bus_req;
    logic          bus_wr;
    logic [SW-1:0] bus_wstrb;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_addr_ok = 1'b0;
    logic          bus_data_ok = 1'b0;
    logic [DW-1:0] bus_rdata = '0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .inst_done   (inst_done),
        .data_req    (data_req),
        .data_wen    (data_wen),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_done   (data_done),
        .flush       (flush),
        .stall_o     (stall_o),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_wstrb   (bus_wstrb),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the single access in flight, if any.
    bit            m_busy = 1'b0;
    bit            m_is_data = 1'b0;
    bit            m_acc = 1'b0;
    bit            m_kill = 1'b0;
    bit            m_inst_done = 1'b0;
    bit            m_data_done = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [SW-1:0] m_wen = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_inst_rdata = '0;
    logic [DW-1:0] m_data_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_update();
        bit nd_i;
        bit nd_d;
        nd_i = 1'b0;
        nd_d = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_acc = 1'b0; m_kill = 1'b0;
            m_addr = '0; m_wen = '0; m_wdata = '0;
            m_inst_rdata = '0; m_data_rdata = '0;
        end else if (!m_busy) begin
            if (!flush && data_req && !m_data_done) begin
                m_busy = 1'b1; m_is_data = 1'b1; m_acc = 1'b0; m_kill = 1'b0;
                m_addr = data_addr; m_wen = data_wen; m_wdata = data_wdata;
            end else if (!flush && inst_req && !m_inst_done) begin
                m_busy = 1'b1; m_is_data = 1'b0; m_acc = 1'b0; m_kill = 1'b0;
                m_addr = inst_addr;
            end
        end else if (!m_acc) begin
            if (bus_addr_ok) begin
                m_acc = 1'b1;
                m_kill = flush;
            end else if (flush) begin
                m_busy = 1'b0;
            end
        end else begin
            if (bus_data_ok) begin
                if (!(m_kill || flush)) begin
                    if (m_is_data) begin
                        m_data_rdata = bus_rdata; nd_d = 1'b1;
                    end else begin
                        m_inst_rdata = bus_rdata; nd_i = 1'b1;
                    end
                end
                m_busy = 1'b0;
            end else if (flush) begin
                m_kill = 1'b1;
            end
        end
        m_inst_done = nd_i;
        m_data_done = nd_d;
    endtask

    task automatic check_outputs();
        bit want_req;
        bit want_wr;
        want_req = m_busy && !m_acc;
        want_wr  = want_req && m_is_data && (m_wen != '0);
        chk("bus_req", bus_req, want_req);
        chk("bus_wr", bus_wr, want_wr);
        chk("bus_wstrb", bus_wstrb, (want_req && m_is_data) ? m_wen : 4'h0);
        if (want_req) chk("bus_addr", bus_addr, m_addr);
        if (want_wr) chk("bus_wdata", bus_wdata, m_wdata);
        chk("inst_done", inst_done, m_inst_done);
        chk("data_done", data_done, m_data_done);
        chk("inst_rdata", inst_rdata, m_inst_rdata);
        chk("data_rdata", data_rdata, m_data_rdata);
    endtask

    // One clock: called at the falling edge with inputs already set.
    task automatic step();
        #1;
        chk("stall_o", stall_o, (inst_req && !m_inst_done) || (data_req && !m_data_done));
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive_bus(input logic a_ok, input logic d_ok, input logic [DW-1:0] rd);
        bus_addr_ok = a_ok;
        bus_data_ok = d_ok;
        bus_rdata   = rd;
        step();
    endtask

    initial begin
        int cnt;
        bit prev_i;
        bit prev_d;
        bit prev_f;
        bit free_i;
        bit free_d;

        // Reset
        @(negedge clk);
        rst = 1'b1;
        drive_bus(1'b0, 1'b0, 32'h0);
        drive_bus(1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        chk("rst_bus_req", bus_req, 64'd0);
        chk("rst_data_rdata", data_rdata, 64'd0);
        chk("rst_inst_rdata", inst_rdata, 64'd0);
        chk("rst_bus_addr", bus_addr, 64'd0);
        chk("rst_stall", stall_o, 64'd0);

        // Single load at 0x1000 with an immediate bus
        data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h0000_1000; data_wdata = 32'h0;
        drive_bus(1'b0, 1'b0, 32'h0);
        chk("t1_bus_req", bus_req, 64'd1);
        chk("t1_bus_addr", bus_addr, 64'h1000);
        chk("t1_bus_wr", bus_wr, 64'd0);
        drive_bus(1'b1, 1'b0, 32'h0);
        chk("t1_req_drop", bus_req, 64'd0);
        drive_bus(1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("t1_done", data_done, 64'd1);
        chk("t1_rdata", data_rdata, 64'hDEAD_BEEF);
        chk("t1_stall", stall_o, 64'd0);
        drive_bus(1'b0, 1'b0, 32'h0);
        data_req = 1'b0;
        chk("t1_no_regrant", bus_req, 64'd0);

        // Simultaneous store and fetch: data first
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h0000_2000; data_wdata = 32'h1234_5678;
        drive_bus(1'b0, 1'b0, 32'h0);
        chk("t2_wr", bus_wr, 64'd1);
        chk("t2_wstrb", bus_wstrb, 64'hF);
        chk("t2_addr", bus_addr, 64'h2000);
        chk("t2_wdata", bus_wdata, 64'h1234_5678);
        drive_bus(1'b1, 1'b0, 32'h0);
        drive_bus(1'b0, 1'b1, 32'hAAAA_5555);
        chk("t2_data_done", data_done, 64'd1);
        chk("t2_stall_inst", stall_o, 64'd1);
        drive_bus(1'b0, 1'b0, 32'h0);
        data_req = 1'b0;
        chk("t2_i_req", bus_req, 64'd1);
        chk("t2_i_addr", bus_addr, 64'hBFC0_0000);
        chk("t2_i_wr", bus_wr, 64'd0);
        chk("t2_i_wstrb", bus_wstrb, 64'd0);
        drive_bus(1'b1, 1'b0, 32'h0);
        drive_bus(1'b0, 1'b1, 32'h2400_0013);
        chk("t2_inst_done", inst_done, 64'd1);
        chk("t2_inst_rdata", inst_rdata, 64'h2400_0013);
        chk("t2_stall_end", stall_o, 64'd0);
        drive_bus(1'b0, 1'b0, 32'h0);
        inst_req = 1'b0;

        // Wait states: addr_ok after 3 cycles, data_ok after 4
        data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h0000_3000;
        drive_bus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("t3_req_hold", bus_req, 64'd1);
            chk("t3_addr_hold", bus_addr, 64'h3000);
            drive_bus(1'b0, 1'b0, 32'h0);
        end
        chk("t3_req_hold", bus_req, 64'd1);
        drive_bus(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) drive_bus(1'b0, 1'b0, 32'h0);
        drive_bus(1'b0, 1'b1, 32'hCAFE_F00D);
        cnt = int'(data_done);
        drive_bus(1'b0, 1'b0, 32'h0);
        data_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cnt += int'(data_done);
            drive_bus(1'b0, 1'b0, 32'h0);
        end
        chk("t3_done_count", cnt, 64'd1);
        chk("t3_rdata", data_rdata, 64'hCAFE_F00D);

        // Flush in D_ADDR before the address is accepted
        data_req = 1'b1; data_addr = 32'h0000_4000;
        drive_bus(1'b0, 1'b0, 32'h0);
        flush = 1'b1;
        drive_bus(1'b0, 1'b0, 32'h0);
        flush = 1'b0; data_req = 1'b0;
        chk("t4_req_drop", bus_req, 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive_bus(1'b0, 1'b1, 32'h7777_7777);
            chk("t4_no_done", data_done, 64'd0);
        end
        chk("t4_rdata_kept", data_rdata, 64'hCAFE_F00D);

        // Flush in I_DATA: bus completes, result discarded
        inst_req = 1'b1; inst_addr = 32'h0000_0100;
        drive_bus(1'b0, 1'b0, 32'h0);
        drive_bus(1'b1, 1'b0, 32'h0);
        flush = 1'b1;
        drive_bus(1'b0, 1'b0, 32'h0);
        flush = 1'b0; inst_req = 1'b0;
        drive_bus(1'b0, 1'b1, 32'h5555_5555);
        chk("t5_no_done", inst_done, 64'd0);
        chk("t5_rdata_kept", inst_rdata, 64'h2400_0013);
        drive_bus(1'b0, 1'b0, 32'h0);
        chk("t5_idle", bus_req, 64'd0);

        // Reset while in D_DATA
        data_req = 1'b1; data_wen = 4'h3; data_addr = 32'h0000_6000; data_wdata = 32'h1122_3344;
        drive_bus(1'b0, 1'b0, 32'h0);
        drive_bus(1'b1, 1'b0, 32'h0);
        rst = 1'b1;
        drive_bus(1'b0, 1'b0, 32'h0);
        rst = 1'b0; data_req = 1'b0;
        chk("t6_bus_req", bus_req, 64'd0);
        chk("t6_bus_wstrb", bus_wstrb, 64'd0);
        chk("t6_bus_addr", bus_addr, 64'd0);
        chk("t6_bus_wdata", bus_wdata, 64'd0);
        chk("t6_data_rdata", data_rdata, 64'd0);
        chk("t6_inst_rdata", inst_rdata, 64'd0);
        drive_bus(1'b0, 1'b1, 32'h9999_9999);
        chk("t6_late_ok_done", data_done, 64'd0);
        chk("t6_late_ok_rdata", data_rdata, 64'd0);

        // Randomized traffic against the model
        prev_i = 1'b0; prev_d = 1'b0; prev_f = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            free_i = (!inst_req || prev_i || prev_f) && !m_inst_done;
            free_d = (!data_req || prev_d || prev_f) && !m_data_done;
            if (free_i) begin
                inst_req  = ($urandom_range(0, 1) == 0);
                inst_addr = $urandom;
            end
            if (free_d) begin
                data_req   = ($urandom_range(0, 2) == 0);
                data_wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            prev_i = m_inst_done;
            prev_d = m_data_done;
            flush  = ($urandom_range(0, 24) == 0);
            prev_f = flush;
            drive_bus(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequences the pipeline's instruction-fetch and data-memory accesses onto one shared SRAM-like bus with split address/data handshakes. It grants the bus to one requester at a time and always serves data before instruction when both are waiting. It latches each request, returns read data and a one-cycle completion pulse, and drives a stall request into the hazard unit while any access is outstanding. It sits between the datapath memory ports and the external bus interface.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width; byte strobes are DW/8 bits

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- inst_req  in  1  fetch request; held until inst_done
- inst_addr  in  AW  fetch address
- inst_rdata  out  DW  fetched word; holds until next fetch completes
- inst_done  out  1  one-cycle completion pulse
- data_req  in  1  load/store request; held until data_done
- data_wen  in  DW/8  byte write enables; 0 means load
- data_addr  in  AW  data address
- data_wdata  in  DW  store data, already byte-lane aligned
- data_rdata  out  DW  load word; holds until next data access completes
- data_done  out  1  one-cycle completion pulse
- flush  in  1  exception flush from the pipeline
- stall_o  out  1  pipeline stall request
- bus_req  out  1  address-phase valid
- bus_wr  out  1  1 = write
- bus_wstrb  out  DW/8  byte strobes
- bus_addr  out  AW  address
- bus_wdata  out  DW  write data
- bus_addr_ok  in  1  address accepted this cycle
- bus_data_ok  in  1  data/response returned this cycle
- bus_rdata  in  DW  read data, valid with bus_data_ok

## Operation
- FSM states: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA.
- Grant in IDLE:
  - If data_req is high, latch data_addr, data_wen and data_wdata, then go to D_ADDR.
  - Otherwise, if inst_req is high, latch inst_addr, then go to I_ADDR.
  - If both are high, data wins.
- *_ADDR: drive bus_req=1 with the latched fields. inst accesses drive bus_wr=0 and bus_wstrb=0. Data accesses drive bus_wr=|wen and bus_wstrb=wen. On bus_addr_ok, go to *_DATA.
- *_DATA: bus_req=0. bus_addr_ok is ignored. On bus_data_ok:
  - Capture bus_rdata into the matching rdata register (writes also capture it; the value is don't-care).
  - Pulse the matching done on the next cycle.
  - Return to IDLE.
- stall_o = (inst_req & ~inst_done) | (data_req & ~data_done), combinational. The pipeline advances only in the done cycle.
- A request still high in IDLE after its done cycle starts a new transaction.
- flush:
  - In *_ADDR with no bus_addr_ok in the same cycle: abandon the access and return to IDLE next cycle. No done pulse.
  - In *_DATA, or *_ADDR with bus_addr_ok in the same cycle: the bus access completes normally, but done is suppressed and the rdata register is not updated.
  - In IDLE: the grant in that cycle is blocked.
- Reset: state IDLE. All outputs, latched fields and both rdata registers are 0.

## Timing
- The grant cycle in IDLE registers the request; bus_req rises the next cycle.
- Minimum latency, with req at cycle 0 and an immediate bus:
  - bus_req at cycle 1, with bus_addr_ok at cycle 1
  - bus_data_ok at cycle 2
  - done and rdata valid at cycle 3
- Back-to-back data then inst: inst grant happens in the IDLE cycle that coincides with data_done.
- bus_data_ok is never expected in the same cycle as its bus_addr_ok. If it arrives in an *_ADDR state, it is ignored.
- All bus_* outputs are registered or decoded from state only; no input-to-bus combinational path.

## Structure
- A shared package holds:
  - state encoding constants (IDLE=0, I_ADDR=1, I_DATA=2, D_ADDR=3, D_DATA=4)
  - AW/DW defaults
- No sub-module. A single FSM plus latch registers is the natural size.

## Test plan
- Single load: data_req, wen=0, addr 0x1000; bus acks addr at cycle 1 and data 0xDEADBEEF at cycle 2 -> data_done at cycle 3, data_rdata=0xDEADBEEF, stall_o low at cycle 3.
- Simultaneous requests: inst 0xBFC00000 and data store 0x2000, wen=0xF, wdata 0x12345678 -> first bus phase is the write with wstrb=0xF, then the fetch; stall_o stays high until inst_done.
- Wait states: bus_addr_ok delayed 3 cycles and bus_data_ok delayed 4 cycles -> bus_req and address stay stable throughout; exactly one done pulse.
- Flush in D_ADDR before bus_addr_ok -> bus_req drops next cycle, no data_done, data_rdata unchanged.
- Flush in I_DATA -> access completes on the bus, no inst_done, inst_rdata keeps its old value.
- Reset asserted in D_DATA -> next cycle IDLE with all outputs 0; a later bus_data_ok is ignored.
